// File: rtl/core_featuremap_maxpool2d_relu.sv
// ReLU followed by 2x2/stride-2 max-pooling over a raster-order feature map, FIFO in / FIFO out.
// Optional MAXPOOL_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt).
module core_featuremap_maxpool2d_relu #(
    parameter int DWIDTH = 32,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] ff_rdata,
    input  logic              ff_empty,
    output logic              ff_rdreq,
    output logic [DWIDTH-1:0] ff_wdata,
    output logic              ff_wrreq,
    input  logic              ff_full,
    output logic              frame_done,
`ifdef MAXPOOL_FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic [1:0]        state_dbg
);

    // Handshakes: a pop (ff_rdreq) is taken whenever it is high; its data is present on
    // ff_rdata one cycle later. A push (ff_wrreq) is only raised while ff_full is low.

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LW = IMG_W / 2;
    localparam int KW = (LW > 1) ? $clog2(LW) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVEN = 2'd1,
        S_ODD  = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              rd_valid;
    logic              out_valid;
    logic              last_pending;
    logic [DWIDTH-1:0] h;
    logic [DWIDTH-1:0] lbuf [LW];

    logic [DWIDTH-1:0] r;
    logic [KW-1:0]     k;
    logic              col_last;
    logic              row_last;

    function automatic logic [DWIDTH-1:0] max_u(input logic [DWIDTH-1:0] a,
                                                input logic [DWIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Negative values (including -0.0) clamp to zero, so unsigned compares are order-correct.
    assign r        = ff_rdata[DWIDTH-1] ? '0 : ff_rdata;
    assign k        = KW'(col >> 1);
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    assign ff_rdreq   = (state != S_IDLE) & ~ff_empty & ~out_valid;
    assign ff_wrreq   = out_valid & ~ff_full;
    assign frame_done = ff_wrreq & last_pending;
    assign state_dbg  = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            col          <= '0;
            row          <= '0;
            rd_valid     <= 1'b0;
            out_valid    <= 1'b0;
            last_pending <= 1'b0;
            h            <= '0;
            ff_wdata     <= '0;
        end else begin
            rd_valid <= ff_rdreq;
            if (ff_wrreq) begin
                out_valid    <= 1'b0;
                last_pending <= 1'b0;
            end
            if (state == S_IDLE) begin
                state <= S_EVEN;
            end else if (rd_valid) begin
                if (col_last) begin
                    col   <= '0;
                    row   <= row_last ? '0 : row + 1'b1;
                    state <= (state == S_EVEN) ? S_ODD : S_EVEN;
                end else begin
                    col <= col + 1'b1;
                end
                if (state == S_EVEN) begin
                    if (!col[0]) h <= r;
                end else if (!col[0]) begin
                    h <= max_u(lbuf[k], r);
                end else begin
                    ff_wdata     <= max_u(h, r);
                    out_valid    <= 1'b1;
                    last_pending <= col_last & row_last;
                end
            end
        end
    end

    // Line buffer holds even-row pair maxima; contents need no reset.
    always_ff @(posedge clock) begin
        if (rd_valid && state == S_EVEN && col[0]) lbuf[k] <= max_u(h, r);
    end

`ifdef MAXPOOL_FRAME_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           frame_cnt <= '0;
        else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_core_featuremap_maxpool2d_relu.sv
// Directed bench for core_featuremap_maxpool2d_relu on a 4x4 map with FIFO models on both sides.
module tb_core_featuremap_maxpool2d_relu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ff_rdata = '0;
    logic        ff_empty = 1'b1;
    logic        ff_full  = 1'b0;
    logic        ff_rdreq, ff_wrreq, frame_done;
    logic [31:0] ff_wdata;
    logic [1:0]  state_dbg;
`ifdef MAXPOOL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    core_featuremap_maxpool2d_relu #(.DWIDTH(32), .IMG_W(4), .IMG_H(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .ff_rdata   (ff_rdata),
        .ff_empty   (ff_empty),
        .ff_rdreq   (ff_rdreq),
        .ff_wdata   (ff_wdata),
        .ff_wrreq   (ff_wrreq),
        .ff_full    (ff_full),
        .frame_done (frame_done),
`ifdef MAXPOOL_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    always #5 clock = ~clock;

    logic [31:0] src_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] hold = '0;
    int cmp_cnt = 0;
    int fail_cnt = 0;
    int fd_cnt = 0;
    int fd_at = 0;
    int fd_bad = 0;
    logic stall_en = 1'b0;
    logic stall_empty = 1'b0;
    int stall_cnt = 0;

    // Upstream FIFO model: data popped on one negedge is presented on the next.
    always @(negedge clock) begin
        if (stall_en) begin
            if (stall_cnt == 0) begin
                stall_empty = ~stall_empty;
                stall_cnt = $urandom_range(3, 1);
            end
            stall_cnt--;
        end else begin
            stall_empty = 1'b0;
        end
        ff_rdata = hold;
        ff_empty = (src_q.size() == 0) || stall_empty;
        #1;
        if (ff_rdreq && src_q.size() > 0) hold = src_q.pop_front();
    end

    // Downstream FIFO model.
    always @(negedge clock) begin
        if (ff_wrreq) begin
            obs_q.push_back(ff_wdata);
            if (frame_done) begin
                fd_cnt++;
                fd_at = obs_q.size();
            end
        end else if (frame_done) begin
            fd_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input string tag, input int n);
        int b = 0;
        while (obs_q.size() < n && b < 400) begin
            @(negedge clock);
            b++;
        end
        repeat (6) @(negedge clock);
        #2;
        check({tag, "_count"}, obs_q.size(), n);
    endtask

    task automatic cmp_frame(input string tag);
        logic [31:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            check(tag, o, e);
        end
        obs_q.delete();
    endtask

    task automatic push_frame(input int start, input int step);
        for (int i = 0; i < 16; i++) src_q.push_back(32'(start + i * step));
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        src_q.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        // Reset state, with a frame already waiting upstream.
        push_frame(1, 1);
        repeat (3) @(posedge clock);
        #2;
        check("rst_rdreq", ff_rdreq, 0);
        check("rst_wrreq", ff_wrreq, 0);
        check("rst_wdata", ff_wdata, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        #1 check("idle_after_release", state_dbg, 0);
        @(posedge clock);
        #2 check("even_after_idle", state_dbg, 1);

        // 1: plain raster frame
        fd_cnt = 0;
        push_exp(6, 8, 14, 16);
        wait_out("t1", 4);
        cmp_frame("t1_data");
        check("t1_fd_cnt", fd_cnt, 1);
        check("t1_fd_at", fd_at, 4);
        check("t1_state_end", state_dbg, 1);

        // 2: negative inputs clamp to zero
        fd_cnt = 0;
        for (int i = 0; i < 8; i++) src_q.push_back(32'hFFFF_FFFB);
        for (int i = 0; i < 8; i++) src_q.push_back(32'h8000_0000);
        push_exp(0, 0, 0, 0);
        wait_out("t2", 4);
        cmp_frame("t2_data");
        check("t2_fd_cnt", fd_cnt, 1);

        // 3: downstream full while a result is pending
        @(posedge clock);
        #2 ff_full = 1'b1;
        push_frame(1, 1);
        repeat (12) @(posedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #2;
            check("t3_wrreq_held", ff_wrreq, 0);
            check("t3_rdreq_held", ff_rdreq, 0);
            check("t3_wdata_held", ff_wdata, 6);
        end
        check("t3_no_push", obs_q.size(), 0);
        @(posedge clock);
        #2 ff_full = 1'b0;
        push_exp(6, 8, 14, 16);
        wait_out("t3", 4);
        cmp_frame("t3_data");

        // 4: upstream empty toggling
        fd_cnt = 0;
        stall_en = 1'b1;
        push_frame(1, 1);
        push_exp(6, 8, 14, 16);
        wait_out("t4", 4);
        stall_en = 1'b0;
        cmp_frame("t4_data");
        check("t4_fd_cnt", fd_cnt, 1);

        // 5: reset after 7 pixels; the pending result must never be pushed
        @(posedge clock);
        #2 ff_full = 1'b1;
        for (int i = 0; i < 7; i++) src_q.push_back(32'(100 + i));
        repeat (15) @(posedge clock);
        #2;
        check("t5_all_popped", src_q.size(), 0);
        check("t5_no_push", obs_q.size(), 0);
        do_reset();
        #1;
        check("t5_rst_wdata", ff_wdata, 0);
        check("t5_rst_wrreq", ff_wrreq, 0);
        check("t5_rst_state", state_dbg, 0);
        ff_full = 1'b0;
        fd_cnt = 0;
        push_frame(1, 1);
        push_exp(6, 8, 14, 16);
        wait_out("t5", 4);
        cmp_frame("t5_data");
        check("t5_fd_cnt", fd_cnt, 1);

        // 6: two back-to-back frames from a fresh reset
        do_reset();
        fd_cnt = 0;
        push_frame(1, 1);
        push_frame(16, -1);
        push_exp(6, 8, 14, 16);
        push_exp(16, 14, 8, 6);
        wait_out("t6", 8);
        cmp_frame("t6_data");
        check("t6_fd_cnt", fd_cnt, 2);
        check("t6_fd_at", fd_at, 8);
`ifdef MAXPOOL_FRAME_CNT_EN
        check("t6_frame_cnt", frame_cnt, 2);
`endif
        check("fd_without_push", fd_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
